// File: rtl/npc_predict_unit.sv
// npc_predict_unit
// Owns the fetch PC register and selects the next fetch PC from the redirect
// sources (EX mispredict, EX jalr, ID jal), the hazard-unit stall and a
// direct-mapped branch target buffer with 2-bit saturating counters.
// Branches are resolved in EX; a disagreement between outcome and the
// prediction carried down the pipe raises a mispredict and flushes.

module npc_predict_unit #(
    parameter int              XLEN        = 32,
    parameter logic [XLEN-1:0] RESET_PC    = {XLEN{1'b0}},
    parameter int              BTB_ENTRIES = 8,
    parameter bit              BTB_EN      = 1'b1
) (
    input  logic            CPU_CLK,
    input  logic            CPU_RST,
    input  logic            StallF,
    output logic [XLEN-1:0] PCF,
    output logic            PredTakenF,
    input  logic            JalD,
    input  logic [XLEN-1:0] JalTarget,
    input  logic            JalrE,
    input  logic [XLEN-1:0] JalrTarget,
    input  logic            BrInstE,
    input  logic            BrTakenE,
    input  logic [XLEN-1:0] BrTargetE,
    input  logic [XLEN-1:0] PCE,
    input  logic            PredTakenE,
    output logic            MispredictE,
    output logic            FlushD,
    output logic            FlushE
);

    localparam int IDX  = $clog2(BTB_ENTRIES);
    localparam int TAGW = XLEN - IDX - 2;

    // Fetch PC state
    logic [XLEN-1:0] pc_reg;
    logic [XLEN-1:0] pc_next;
    logic [XLEN-1:0] pc_plus4;

    // BTB storage: valid bits are resettable, the rest is don't-care until allocated
    logic [BTB_ENTRIES-1:0] valid_reg;
    logic [TAGW-1:0]        tag_reg    [BTB_ENTRIES];
    logic [XLEN-1:0]        target_reg [BTB_ENTRIES];
    logic [1:0]             cnt_reg    [BTB_ENTRIES];

    // Lookup side (fetch PC)
    logic [IDX-1:0]         f_idx;
    logic [TAGW-1:0]        f_tag;
    logic [BTB_ENTRIES-1:0] f_match;
    logic                   pred_f;

    // Update side (EX branch PC)
    logic [IDX-1:0]         e_idx;
    logic [TAGW-1:0]        e_tag;
    logic [BTB_ENTRIES-1:0] e_match;
    logic                   e_hit;
    logic                   upd_en;
    logic                   upd_write;
    logic [1:0]             cnt_next;

    logic mispredict;

    // The low two PC bits of the EX instruction never address the BTB
    logic unused_pce_lsb;
    assign unused_pce_lsb = ^PCE[1:0];

    assign f_idx = pc_reg[IDX+1:2];
    assign f_tag = pc_reg[XLEN-1:IDX+2];
    assign e_idx = PCE[IDX+1:2];
    assign e_tag = PCE[XLEN-1:IDX+2];

    // Per-entry tag comparison for both the fetch lookup and the EX update
    generate
        for (genvar gi = 0; gi < BTB_ENTRIES; gi++) begin : g_match
            assign f_match[gi] = valid_reg[gi] && (tag_reg[gi] == f_tag);
            assign e_match[gi] = valid_reg[gi] && (tag_reg[gi] == e_tag);
        end
    endgenerate

    // Prediction reads the pre-update contents; no same-cycle bypass
    assign pred_f = BTB_EN && f_match[f_idx] && cnt_reg[f_idx][1];
    assign e_hit  = e_match[e_idx];

    assign mispredict = BrInstE && (BrTakenE != PredTakenE);

    assign MispredictE = mispredict;
    assign FlushD      = mispredict | JalrE | JalD;
    assign FlushE      = mispredict | JalrE;
    assign PCF         = pc_reg;
    assign PredTakenF  = pred_f;

    // +4 wraps modulo 2^XLEN and leaves bits [1:0] untouched
    assign pc_plus4 = pc_reg + XLEN'(4);

    // Next-PC selection: redirects first, then stall, then prediction
    always_comb begin
        pc_next = pc_plus4;
        if (mispredict) begin
            pc_next = BrTakenE ? BrTargetE : (PCE + XLEN'(4));
        end else if (JalrE) begin
            pc_next = JalrTarget;
        end else if (JalD) begin
            pc_next = JalTarget;
        end else if (StallF) begin
            pc_next = pc_reg;
        end else if (pred_f) begin
            pc_next = target_reg[f_idx];
        end
    end

    // Counter update for the addressed entry; a fresh allocation starts weakly taken
    always_comb begin
        cnt_next = 2'b10;
        if (e_hit) begin
            if (BrTakenE) begin
                cnt_next = (cnt_reg[e_idx] == 2'b11) ? 2'b11 : cnt_reg[e_idx] + 2'b01;
            end else begin
                cnt_next = (cnt_reg[e_idx] == 2'b00) ? 2'b00 : cnt_reg[e_idx] - 2'b01;
            end
        end
    end

    // A miss that resolved not-taken leaves the BTB untouched
    assign upd_en    = BTB_EN && BrInstE;
    assign upd_write = upd_en && (e_hit || BrTakenE);

    // Fetch PC register
    always_ff @(posedge CPU_CLK) begin
        if (CPU_RST) begin
            pc_reg <= RESET_PC;
        end else begin
            pc_reg <= pc_next;
        end
    end

    // BTB update at the EX branch index; reset clears valids and suppresses the write
    always_ff @(posedge CPU_CLK) begin
        if (CPU_RST) begin
            valid_reg <= '0;
        end else if (upd_write) begin
            valid_reg[e_idx] <= 1'b1;
            tag_reg[e_idx]   <= e_tag;
            cnt_reg[e_idx]   <= cnt_next;
            if (BrTakenE) begin
                target_reg[e_idx] <= BrTargetE;
            end
        end
    end

endmodule
